// File: rtl/scan_chain_loader_pkg.sv
// rtl/scan_chain_loader_pkg.sv - shared types and sizing helpers for the scan chain loader
package scan_cfg_pkg;

  // Loader control states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } sc_state_e;

  localparam int DEF_SC_LENGTH  = 1024;
  localparam int DEF_WORD_WIDTH = 32;

  // Bits taken from the final word; a chain that is an exact multiple uses a full word
  function automatic int last_word_bits(int len, int ww);
    return ((len % ww) == 0) ? ww : (len % ww);
  endfunction

  // Number of words needed to fill the chain
  function automatic int word_count(int len, int ww);
    return (len + ww - 1) / ww;
  endfunction

  localparam int DEF_LAST_WORD_BITS = last_word_bits(DEF_SC_LENGTH, DEF_WORD_WIDTH);
  localparam int DEF_WORD_COUNT     = word_count(DEF_SC_LENGTH, DEF_WORD_WIDTH);

endpackage

// File: rtl/scan_chain_loader_if.sv
// rtl/scan_chain_loader_if.sv - configuration word stream between bitstream path and loader
interface scan_chain_loader_if
  import scan_cfg_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
);

  logic [WORD_WIDTH-1:0] word_i;
  logic                  word_valid;
  logic                  word_ready;

  // Source side drives words; loader side accepts them
  modport master (output word_i, output word_valid, input word_ready);
  modport slave  (input word_i, input word_valid, output word_ready);

endinterface

// File: rtl/scan_chain_loader_piso_shreg.sv
// rtl/scan_chain_loader_piso_shreg.sv - parallel-load serial-out word register with bits-left count
module piso_shreg #(
  parameter int WORD_WIDTH = 32,
  parameter int BW         = $clog2(WORD_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  flush,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] load_word,
  input  logic [BW-1:0]         load_bits,
  input  logic                  shift,
  output logic                  next_lsb,
  output logic [BW-1:0]         bits_left
);

  logic [WORD_WIDTH-1:0] shreg;
  logic [WORD_WIDTH-1:0] shreg_nxt;
  logic [BW-1:0]         bits_nxt;

  // A load wins over a shift so a new word can replace the one finishing this cycle
  always_comb begin
    shreg_nxt = shreg;
    bits_nxt  = bits_left;
    if (flush) begin
      shreg_nxt = '0;
      bits_nxt  = '0;
    end else if (load) begin
      shreg_nxt = load_word;
      bits_nxt  = load_bits;
    end else if (shift) begin
      shreg_nxt = shreg >> 1;
      bits_nxt  = bits_left - BW'(1);
    end
  end

  // Exposed so the owner can register the bit it will present next cycle
  assign next_lsb = shreg_nxt[0];

  // Word register and its remaining-bit count
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      shreg     <= '0;
      bits_left <= '0;
    end else begin
      shreg     <= shreg_nxt;
      bits_left <= bits_nxt;
    end
  end

endmodule

// File: rtl/scan_chain_loader.sv
// rtl/scan_chain_loader.sv - serializes configuration words LSB first into the core scan chain
module scan_chain_loader
  import scan_cfg_pkg::*;
#(
  parameter int SC_LENGTH  = DEF_SC_LENGTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  clr_first,
  input  logic                  abort,
  scan_chain_loader_if.slave    wr,
  output logic                  sc_en,
  output logic                  sc_data,
  output logic                  sc_clear_n,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(SC_LENGTH + 1);
  localparam int BW = $clog2(WORD_WIDTH + 1);
  localparam logic [CW-1:0] LEN_C = CW'(SC_LENGTH);

  sc_state_e      state;
  sc_state_e      state_nxt;
  logic [CW-1:0]  bit_cnt;
  logic [CW-1:0]  cnt_nxt;
  logic           ready;
  logic           sh_load;
  logic           sh_shift;
  logic           sh_flush;
  logic [BW-1:0]  load_bits;
  logic           next_lsb;
  logic [BW-1:0]  bits_left;
  logic           word_last_bit;
  logic           more_after_word;

  piso_shreg #(
    .WORD_WIDTH (WORD_WIDTH),
    .BW         (BW)
  ) u_shreg (
    .clk       (clk),
    .clear     (clear),
    .flush     (sh_flush),
    .load      (sh_load),
    .load_word (wr.word_i),
    .load_bits (load_bits),
    .shift     (sh_shift),
    .next_lsb  (next_lsb),
    .bits_left (bits_left)
  );

  assign word_last_bit   = (bits_left == BW'(1));
  assign more_after_word = (bit_cnt != CW'(1));
  assign wr.word_ready   = ready;

  // Next state, bit counter and word register control; ready never looks at word_valid
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    ready     = 1'b0;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_flush  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_nxt   = LEN_C;
          state_nxt = clr_first ? ST_CLR : ST_LOAD;
        end
      end
      ST_CLR: begin
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        ready = 1'b1;
        if (wr.word_valid) begin
          sh_load   = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sh_shift = 1'b1;
        cnt_nxt  = bit_cnt - CW'(1);
        if (word_last_bit) begin
          if (more_after_word) begin
            ready = 1'b1;
            if (wr.word_valid) begin
              sh_load = 1'b1;
            end else begin
              state_nxt = ST_LOAD;
            end
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      sh_load   = 1'b0;
      sh_shift  = 1'b0;
      sh_flush  = 1'b1;
    end
  end

  // A freshly loaded word contributes min(WORD_WIDTH, bits still to shift)
  always_comb begin
    load_bits = BW'(WORD_WIDTH);
    if (32'(cnt_nxt) < WORD_WIDTH) begin
      load_bits = BW'(cnt_nxt);
    end
  end

  // State, counter and registered chain-facing outputs derived from the next state
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      sc_en      <= 1'b0;
      sc_data    <= 1'b0;
      sc_clear_n <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= cnt_nxt;
      sc_en      <= (state_nxt == ST_SHIFT);
      sc_data    <= (state_nxt == ST_SHIFT) & next_lsb;
      sc_clear_n <= (state_nxt != ST_CLR);
      busy       <= (state_nxt != ST_IDLE);
      done       <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_scan_chain_loader.sv
// tb/tb_scan_chain_loader.sv - self-checking bench for scan_chain_loader with a chain model
module tb_scan_chain_loader;
  import scan_cfg_pkg::*;

  localparam int WW = 4;
  localparam int L0 = 8;
  localparam int L1 = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          clear      [2];
  logic          start      [2];
  logic          clr_first  [2];
  logic          abort_s    [2];
  logic [WW-1:0] word_i     [2];
  logic          word_valid [2];
  logic          word_ready [2];
  logic          sc_en      [2];
  logic          sc_data    [2];
  logic          sc_clear_n [2];
  logic          busy       [2];
  logic          done       [2];
  logic          preload    [2];

  scan_chain_loader_if #(.WORD_WIDTH(WW)) wif0 ();
  scan_chain_loader_if #(.WORD_WIDTH(WW)) wif1 ();

  assign wif0.word_i     = word_i[0];
  assign wif0.word_valid = word_valid[0];
  assign word_ready[0]   = wif0.word_ready;
  assign wif1.word_i     = word_i[1];
  assign wif1.word_valid = word_valid[1];
  assign word_ready[1]   = wif1.word_ready;

  scan_chain_loader #(.SC_LENGTH(L0), .WORD_WIDTH(WW)) dut0 (
    .clk(clk), .clear(clear[0]), .start(start[0]), .clr_first(clr_first[0]), .abort(abort_s[0]),
    .wr(wif0), .sc_en(sc_en[0]), .sc_data(sc_data[0]), .sc_clear_n(sc_clear_n[0]),
    .busy(busy[0]), .done(done[0])
  );

  scan_chain_loader #(.SC_LENGTH(L1), .WORD_WIDTH(WW)) dut1 (
    .clk(clk), .clear(clear[1]), .start(start[1]), .clr_first(clr_first[1]), .abort(abort_s[1]),
    .wr(wif1), .sc_en(sc_en[1]), .sc_data(sc_data[1]), .sc_clear_n(sc_clear_n[1]),
    .busy(busy[1]), .done(done[1])
  );

  // Chain model and event log: top L bits of a 16-bit register, new bits enter at bit 15
  int          cyc = 0;
  logic [15:0] chain      [2];
  int          en_cnt     [2];
  int          hs_cnt     [2];
  int          done_cnt   [2];
  int          done_cyc   [2];
  int          clr_cnt    [2];
  int          overlap    [2];
  logic        bits_log   [2][1024];
  int          en_cyc_log [2][1024];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (preload[d]) chain[d] <= 16'hFFFF;
      else if (sc_en[d]) chain[d] <= {sc_data[d], chain[d][15:1]};
      else if (!sc_clear_n[d]) chain[d] <= 16'h0000;
      if (sc_en[d]) begin
        if (en_cnt[d] < 1024) begin
          bits_log[d][en_cnt[d]]   <= sc_data[d];
          en_cyc_log[d][en_cnt[d]] <= cyc;
        end
        en_cnt[d] <= en_cnt[d] + 1;
      end
      if (sc_en[d] && !sc_clear_n[d]) overlap[d] <= overlap[d] + 1;
      if (!sc_clear_n[d]) clr_cnt[d] <= clr_cnt[d] + 1;
      if (word_valid[d] && word_ready[d]) hs_cnt[d] <= hs_cnt[d] + 1;
      if (done[d]) begin
        done_cnt[d] <= done_cnt[d] + 1;
        done_cyc[d] <= cyc;
      end
    end
  end

  int tests = 0;
  int fails = 0;
  logic [WW-1:0] words [8];

  function automatic int len_of(int d);
    return (d == 0) ? L0 : L1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(int d, string tag);
    chk({tag, "_sc_en"}, 32'(sc_en[d]), 0);
    chk({tag, "_sc_data"}, 32'(sc_data[d]), 0);
    chk({tag, "_sc_clear_n"}, 32'(sc_clear_n[d]), 1);
    chk({tag, "_word_ready"}, 32'(word_ready[d]), 0);
    chk({tag, "_busy"}, 32'(busy[d]), 0);
    chk({tag, "_done"}, 32'(done[d]), 0);
  endtask

  // One load on loader d using words[]; optional clear, boundary stall, abort or a stray start
  task automatic run(int d, bit clr, int stall_after, int stall_n, int abort_at, int restart_at,
                     output logic [15:0] got_chain);
    int L, nw, e0, h0, d0, c0, o0, k, withheld, budget, last, span_exp;
    bit hs, aborted, chk_zero, hold;
    logic [15:0] exp_chain, seq;
    L = len_of(d);
    nw = (L + WW - 1) / WW;
    e0 = en_cnt[d]; h0 = hs_cnt[d]; d0 = done_cnt[d]; c0 = clr_cnt[d]; o0 = overlap[d];
    k = 0; withheld = 0; budget = 0; aborted = 0; chk_zero = 0;
    exp_chain = '0;
    for (int i = 0; i < L; i++) exp_chain[i] = words[i / WW][i % WW];
    @(negedge clk);
    start[d] = 1'b1; clr_first[d] = clr;
    @(negedge clk);
    start[d] = 1'b0; clr_first[d] = 1'b0;
    while (done_cnt[d] == d0 && !aborted && budget < 200) begin
      if (chk_zero) begin
        chk("clr_chain_zero", 32'(chain[d] >> (16 - L)), 0);
        chk_zero = 0;
      end
      if (!sc_clear_n[d]) chk_zero = 1;
      hold = (stall_after >= 0) && (k == stall_after + 1) && (withheld < stall_n);
      if (k < nw && !hold) begin
        word_valid[d] = 1'b1;
        word_i[d] = words[k];
      end else begin
        word_valid[d] = 1'b0;
      end
      if (hold && word_ready[d]) withheld++;
      hs = word_valid[d] && word_ready[d];
      if (abort_at >= 0 && (en_cnt[d] - e0) == abort_at) begin
        abort_s[d] = 1'b1;
        aborted = 1;
      end
      if (restart_at >= 0 && (en_cnt[d] - e0) == restart_at) start[d] = 1'b1;
      @(posedge clk);
      if (hs) k++;
      @(negedge clk);
      abort_s[d] = 1'b0;
      start[d] = 1'b0;
      budget++;
    end
    word_valid[d] = 1'b0;
    got_chain = chain[d] >> (16 - L);
    if (aborted) begin
      chk("abort_busy", 32'(busy[d]), 0);
      chk("abort_sc_en", 32'(sc_en[d]), 0);
      chk("abort_sc_clear_n", 32'(sc_clear_n[d]), 1);
      chk("abort_shifts", 32'(en_cnt[d] - e0), 32'(abort_at + 1));
      repeat (5) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt[d] - d0), 0);
      chk("abort_no_more_shifts", 32'(en_cnt[d] - e0), 32'(abort_at + 1));
    end else begin
      chk("timeout", 32'(budget < 200), 1);
      chk("shift_count", 32'(en_cnt[d] - e0), 32'(L));
      chk("handshakes", 32'(hs_cnt[d] - h0), 32'(nw));
      chk("done_pulses", 32'(done_cnt[d] - d0), 1);
      seq = '0;
      for (int i = 0; i < L; i++) seq[i] = bits_log[d][e0 + i];
      chk("sc_data_order", 32'(seq), 32'(exp_chain));
      chk("chain_contents", 32'(got_chain), 32'(exp_chain));
      last = en_cyc_log[d][e0 + L - 1];
      chk("done_latency", 32'(done_cyc[d] - last), 1);
      span_exp = L + ((stall_after >= 0) ? stall_n : 0);
      chk("shift_span", 32'(last - en_cyc_log[d][e0] + 1), 32'(span_exp));
      chk("clear_cycles", 32'(clr_cnt[d] - c0), clr ? 1 : 0);
      chk("en_clear_overlap", 32'(overlap[d] - o0), 0);
      chk("idle_after_done", 32'(busy[d]), 0);
    end
  endtask

  initial begin
    logic [15:0] got;
    int e0;
    for (int d = 0; d < 2; d++) begin
      clear[d] = 1'b0; start[d] = 1'b0; clr_first[d] = 1'b0; abort_s[d] = 1'b0;
      word_i[d] = '0; word_valid[d] = 1'b0; preload[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk_reset_outputs(0, "reset0");
    chk_reset_outputs(1, "reset1");
    clear[0] = 1'b1; clear[1] = 1'b1;
    repeat (2) @(negedge clk);

    // Case 1: 8-bit chain, words A then 5 back to back
    words[0] = 4'hA; words[1] = 4'h5;
    run(0, 0, -1, 0, -1, -1, got);
    chk("t1_chain_5A", 32'(got), 32'h5A);

    // Case 2: 10-bit chain, partial last word
    words[0] = 4'hF; words[1] = 4'h0; words[2] = 4'hE;
    run(1, 0, -1, 0, -1, -1, got);
    chk("t2_chain_20F", 32'(got), 32'h20F);

    // Case 3: three-cycle stall at the first word boundary
    words[0] = 4'hA; words[1] = 4'h5;
    run(0, 0, 0, 3, -1, -1, got);
    chk("t3_chain_5A", 32'(got), 32'h5A);

    // Case 4: chain preloaded to ones, clear pulsed first
    @(negedge clk); preload[1] = 1'b1;
    @(negedge clk); preload[1] = 1'b0;
    words[0] = 4'h3; words[1] = 4'hC; words[2] = 4'h1;
    run(1, 1, -1, 0, -1, -1, got);

    // Case 5: abort after three shifts, then a fresh full load
    words[0] = 4'h6; words[1] = 4'h9; words[2] = 4'h2;
    run(1, 0, -1, 0, 3, -1, got);
    words[0] = 4'hB; words[1] = 4'h4; words[2] = 4'h3;
    run(1, 0, -1, 0, -1, -1, got);

    // Case 6a: stray start while shifting is ignored
    words[0] = 4'h7; words[1] = 4'hE;
    run(0, 0, -1, 0, -1, 5, got);

    // Case 6b: async clear mid-shift forces reset outputs within the cycle
    words[0] = 4'h9; words[1] = 4'h6; words[2] = 4'h1;
    e0 = en_cnt[1];
    @(negedge clk); start[1] = 1'b1;
    @(negedge clk); start[1] = 1'b0; word_valid[1] = 1'b1; word_i[1] = words[0];
    for (int n = 0; n < 40 && (en_cnt[1] - e0) < 3; n++) @(negedge clk);
    chk("t6_mid_shift_busy", 32'(busy[1]), 1);
    #2 clear[1] = 1'b0;
    #1 chk_reset_outputs(1, "t6_async");
    word_valid[1] = 1'b0;
    @(negedge clk); clear[1] = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_stays_idle", 32'(busy[1]), 0);
    run(1, 0, -1, 0, -1, -1, got);

    // Randomized loads on either chain length
    for (int r = 0; r < 8; r++) begin
      int d, st;
      d = int'($urandom_range(0, 1));
      for (int w = 0; w < 3; w++) words[w] = WW'($urandom);
      st = ($urandom_range(0, 2) == 0) ? 0 : -1;
      run(d, 1'($urandom_range(0, 1)), st, int'($urandom_range(1, 3)), -1, -1, got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scan_chain_loader.md
Name: scan_chain_loader

Overview:
Transmit-side driver for the FPGA core configuration scan chain. Accepts configuration words over a valid/ready stream and serializes them, LSB first, into the chain's serial data/enable inputs. Shifts exactly SC_LENGTH bits, optionally clears the chain first, then reports completion. Sits between the bitstream buffer/decrypt path and the core's scan chain.

Parameters:
SC_LENGTH, 1024, number of chain bits to shift per load (>=1)
WORD_WIDTH, 32, width of incoming configuration words (>=1)

Ports:
clk  input  1  single clock; chain shifts on the same edge
clear  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins a load; ignored unless IDLE
clr_first  input  1  sampled with start; 1 = pulse chain clear before shifting
abort  input  1  return to IDLE immediately; done is not raised
word_i  input  WORD_WIDTH  configuration word
word_valid  input  1  word_i valid
word_ready  output  1  loader accepts word_i this cycle
sc_en  output  1  chain shift enable
sc_data  output  1  chain serial data
sc_clear_n  output  1  chain clear, active-low
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse after the last bit is shifted

Behaviour:
- Reset (clear=0): state IDLE; sc_en=0, sc_data=0, sc_clear_n=1, word_ready=0, busy=0, done=0; all counters 0.
- All chain-facing outputs are registered. sc_en=1 for a cycle means the chain shifts on the following posedge.
- The chain gives en priority over clear. The loader never drives sc_en=1 while sc_clear_n=0.
- States: IDLE, CLR, LOAD, SHIFT, DONE.
- IDLE + start: go to CLR if clr_first=1, else LOAD. Load bit counter with SC_LENGTH.
- CLR: sc_clear_n=0 for exactly one cycle, then LOAD.
- LOAD: word_ready=1. On word_valid&&word_ready, latch word_i into the shift register and go to SHIFT. sc_en stays 0 while waiting.
- SHIFT: each cycle, sc_en=1 and sc_data=shreg[0]. Then shreg shifts right and the bit counter decrements.
  - Bits used from the current word = min(WORD_WIDTH, bits remaining).
  - The final word may be partial: only its low (SC_LENGTH mod WORD_WIDTH) bits are shifted, and the upper bits are discarded.
- Back-to-back streaming:
  - word_ready is also 1 during the last SHIFT cycle of a word, provided bits remain after that word.
  - A word accepted then continues shifting with no bubble, so sc_en stays high.
  - word_ready is a function of state and counters only, with no combinational path from word_valid.
- Stall: if no word is accepted at a word boundary, go to LOAD. sc_en=0 and no spurious shift occurs.
- When the bit counter reaches 0, go to DONE. DONE drives done=1 for one cycle, then IDLE.
  - Latency: done is asserted 1 cycle after the last sc_en=1 cycle.
- Bit ordering: the first bit shifted is word0[0], and it ends at chain position 0. After a full load, the chain contents = {..., word1, word0}, truncated to SC_LENGTH.
- abort (any non-IDLE state): next cycle IDLE; sc_en=0, sc_clear_n=1; the partially shifted word is dropped and done is not pulsed. abort has priority over start and handshake.
- start while busy is ignored.
- Async reset mid-shift: outputs take their reset values immediately. The chain keeps its partial contents, and the loader does not clear it.
- Counter widths: $clog2(SC_LENGTH+1) and $clog2(WORD_WIDTH+1).

Decomposition:
- Shared package scan_cfg_pkg:
  - state encoding enum;
  - default SC_LENGTH/WORD_WIDTH constants;
  - localparams for the last-word bit count (SC_LENGTH % WORD_WIDTH, mapped to WORD_WIDTH when 0) and the word count ceil(SC_LENGTH/WORD_WIDTH).
- One natural sub-module: piso_shreg, a WORD_WIDTH parallel-load shift register with a load/shift/bit-remaining interface. The FSM and counters stay in the top module.

Test Plan:
1. SC_LENGTH=8, WORD_WIDTH=4, words 0xA then 0x5 with valid held high, clr_first=0 -> sc_en high for exactly 8 consecutive cycles; sc_data sequence 0,1,0,1,1,0,1,0; chain model = 8'h5A; done pulses 1 cycle after the last shift.
2. SC_LENGTH=10, WORD_WIDTH=4, words 0xF,0x0,0xE -> 3 handshakes; last word shifts bits 0,1 only; chain = 10'b10_0000_1111; total sc_en cycles = 10.
3. Stall: in case 1, drop word_valid for 3 cycles after the first word -> sc_en low for those cycles; final chain still 8'h5A; no extra shifts.
4. clr_first=1 with the chain preloaded to all ones -> sc_clear_n low exactly 1 cycle, never overlapping sc_en; then a normal load completes.
5. abort after 3 shifts -> next cycle busy=0, sc_en=0, no done pulse; a new start then completes a full load correctly.
6. Async clear asserted mid-shift, plus a start pulse while busy -> outputs at reset values within the same cycle; the ignored start does not restart the counters.
